// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: D/E-boundary issue controller for the multiply/divide unit.
// Holds the E-stage MD op register, drives the MD unit start/op/operands,
// tracks MD occupancy with a shadow latency counter and stalls D when an
// MD-class instruction would reach a busy unit. The shadow counter is
// cross-checked against the MD unit's own busy flag (sticky o_err).
//
// Optional feature macro: MD_PERF_EN (stall/issue performance counters).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_d_valid            D-stage instruction valid
//   i_d_md_op[3:0]       D-stage MD op (0..3 start, 4..5 move-to, 6..7 move-from, 8..15 none)
//   i_d_rs_val/rt_val    forwarded operands
//   i_md_busy            busy flag from the MD unit
//   o_stall_d            freeze PC/IF/D, bubble into E (combinational)
//   o_md_start           start pulse to MD unit
//   o_md_op/srca/srcb    E-register op and operands to MD unit
//   o_md_occupied        shadow busy (remaining latency != 0)
//   o_err                sticky shadow/unit busy mismatch
//   o_perf_stall_cnt     MD stall cycles (0 unless MD_PERF_EN)
//   o_perf_issue_cnt     start ops issued (0 unless MD_PERF_EN)
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_d_valid,
  input  logic [3:0]  i_d_md_op,
  input  logic [31:0] i_d_rs_val,
  input  logic [31:0] i_d_rt_val,
  input  logic        i_md_busy,
  output logic        o_stall_d,
  output logic        o_md_start,
  output logic [3:0]  o_md_op,
  output logic [31:0] o_md_srca,
  output logic [31:0] o_md_srcb,
  output logic        o_md_occupied,
  output logic        o_err,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_issue_cnt
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REM_W  = 4;

  localparam logic [OP_W-1:0]  OP_NONE    = OP_W'(8);
  localparam logic [REM_W-1:0] MULT_LAT_C = REM_W'(MULT_LAT);
  localparam logic [REM_W-1:0] DIV_LAT_C  = REM_W'(DIV_LAT);

  logic [OP_W-1:0]   r_e_op;
  logic [DATA_W-1:0] r_e_a;
  logic [DATA_W-1:0] r_e_b;
  logic [REM_W-1:0]  r_rem;
  logic              r_err;

  logic w_e_start;
  logic w_occupied;
  logic w_busy_now;
  logic w_d_is_md;
  logic w_stall_d;

  // Op classes: 0..3 start the unit, 4..7 are moves, 8..15 are not MD ops.
  assign w_e_start  = (r_e_op[3:2] == 2'b00);
  assign w_d_is_md  = ~i_d_md_op[3];
  assign w_occupied = (r_rem != '0);
  // Busy from registered state only, so the stall has no input-to-input path
  // through the MD unit.
  assign w_busy_now = w_e_start | w_occupied;
  assign w_stall_d  = i_d_valid & w_d_is_md & w_busy_now;

  // E-stage op register: load from D, or insert a bubble on stall/invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_op <= OP_NONE;
      r_e_a  <= '0;
      r_e_b  <= '0;
    end else if (i_d_valid && !w_stall_d && w_d_is_md) begin
      r_e_op <= i_d_md_op;
      r_e_a  <= i_d_rs_val;
      r_e_b  <= i_d_rt_val;
    end else begin
      r_e_op <= OP_NONE;
      r_e_a  <= '0;
      r_e_b  <= '0;
    end
  end

  // Shadow latency counter: loaded as the unit latches the op, then counts
  // down to hit zero on the same edge the unit drops busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
    end else if (w_e_start) begin
      r_rem <= r_e_op[1] ? DIV_LAT_C : MULT_LAT_C;
    end else if (w_occupied) begin
      r_rem <= r_rem - REM_W'(1);
    end
  end

  // Sticky mismatch between shadow occupancy and the unit's busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (i_md_busy != w_occupied) begin
      r_err <= 1'b1;
    end
  end

`ifdef MD_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_issue_cnt;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_issue_cnt <= '0;
    end else begin
      if (w_stall_d) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_e_start) r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_issue_cnt = r_perf_issue_cnt;
`else
  assign o_perf_stall_cnt = '0;
  assign o_perf_issue_cnt = '0;
`endif

  assign o_stall_d     = w_stall_d;
  assign o_md_start    = w_e_start;
  assign o_md_op       = r_e_op;
  assign o_md_srca     = r_e_a;
  assign o_md_srcb     = r_e_b;
  assign o_md_occupied = w_occupied;
  assign o_err         = r_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small MD-unit busy model.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [3:0]  d_md_op;
  logic [31:0] d_rs_val;
  logic [31:0] d_rt_val;
  logic        md_busy;
  logic        stall_d;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_srca;
  logic [31:0] md_srcb;
  logic        md_occupied;
  logic        err;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_issue_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] unit_cnt;
  logic       force_busy;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_d_valid        (d_valid),
    .i_d_md_op        (d_md_op),
    .i_d_rs_val       (d_rs_val),
    .i_d_rt_val       (d_rt_val),
    .i_md_busy        (md_busy),
    .o_stall_d        (stall_d),
    .o_md_start       (md_start),
    .o_md_op          (md_op),
    .o_md_srca        (md_srca),
    .o_md_srcb        (md_srcb),
    .o_md_occupied    (md_occupied),
    .o_err            (err),
    .o_perf_stall_cnt (perf_stall_cnt),
    .o_perf_issue_cnt (perf_issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MD unit stand-in: latches on the edge after start, busy for 5 (mult) / 10 (div).
  always @(posedge clk) begin
    if (reset) unit_cnt <= 4'd0;
    else if (md_start) unit_cnt <= md_op[1] ? 4'd10 : 4'd5;
    else if (unit_cnt != 4'd0) unit_cnt <= unit_cnt - 4'd1;
  end
  assign md_busy = (unit_cnt != 4'd0) | force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    d_valid  = v;
    d_md_op  = op;
    d_rs_val = a;
    d_rt_val = b;
    #1;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_issue;
    reset = 1'b1;
    force_busy = 1'b0;
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    cyc;
    cyc;
    // Reset state
    chk("rst_md_op", 32'(md_op), 32'd8);
    chk("rst_srca", md_srca, 32'd0);
    chk("rst_srcb", md_srcb, 32'd0);
    chk("rst_start", 32'(md_start), 32'd0);
    chk("rst_stall", 32'(stall_d), 32'd0);
    chk("rst_occ", 32'(md_occupied), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_issue", perf_issue_cnt, 32'd0);
    reset = 1'b0;
    cyc;

    // mult 3 * -2, then mfhi waiting in D
    drive(1'b1, 4'd0, 32'd3, 32'hFFFF_FFFE);
    chk("t1_nostall_mult", 32'(stall_d), 32'd0);
    cyc;
    chk("t1_start", 32'(md_start), 32'd1);
    chk("t1_op", 32'(md_op), 32'd0);
    chk("t1_srca", md_srca, 32'd3);
    chk("t1_srcb", md_srcb, 32'hFFFF_FFFE);
    drive(1'b1, 4'd6, 32'h11, 32'h22);
    for (int k = 0; k < 6; k++) begin
      chk("t1_stall", 32'(stall_d), 32'd1);
      chk("t1_start_pulse", 32'(md_start), (k == 0) ? 32'd1 : 32'd0);
      chk("t1_occ", 32'(md_occupied), (k == 0) ? 32'd0 : 32'd1);
      cyc;
    end
    chk("t1_stall_end", 32'(stall_d), 32'd0);
    chk("t1_occ_end", 32'(md_occupied), 32'd0);
    cyc;
    chk("t1_mfhi_op", 32'(md_op), 32'd6);
    chk("t1_mfhi_start", 32'(md_start), 32'd0);
    chk("t1_mfhi_srca", md_srca, 32'h11);
    chk("t1_err", 32'(err), 32'd0);
`ifdef MD_PERF_EN
    exp_stall = 32'd6;
    exp_issue = 32'd1;
`else
    exp_stall = 32'd0;
    exp_issue = 32'd0;
`endif
    chk("t1_perf_stall", perf_stall_cnt, exp_stall);
    chk("t1_perf_issue", perf_issue_cnt, exp_issue);
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    cyc;

    // div 7 / 0, then mtlo waiting: DIV_LAT+1 stall cycles
    drive(1'b1, 4'd2, 32'd7, 32'd0);
    cyc;
    chk("t2_start", 32'(md_start), 32'd1);
    chk("t2_op", 32'(md_op), 32'd2);
    chk("t2_srcb", md_srcb, 32'd0);
    drive(1'b1, 4'd5, 32'd5, 32'd0);
    for (int k = 0; k < 11; k++) begin
      chk("t2_stall", 32'(stall_d), 32'd1);
      chk("t2_occ", 32'(md_occupied), (k == 0) ? 32'd0 : 32'd1);
      cyc;
    end
    chk("t2_stall_end", 32'(stall_d), 32'd0);
    chk("t2_occ_end", 32'(md_occupied), 32'd0);
    cyc;
    chk("t2_mtlo_op", 32'(md_op), 32'd5);
    chk("t2_mtlo_srca", md_srca, 32'd5);
    chk("t2_err", 32'(err), 32'd0);

    // multu followed by five non-MD instructions: no stalls
    drive(1'b1, 4'd1, 32'd1, 32'd2);
    cyc;
    chk("t3_start", 32'(md_start), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(8 + i), 32'hAA00 + 32'(i), 32'hBB00);
      chk("t3_nostall", 32'(stall_d), 32'd0);
      cyc;
      chk("t3_none_op", 32'(md_op), 32'd8);
      chk("t3_none_srca", md_srca, 32'd0);
    end
    chk("t3_occ_tail", 32'(md_occupied), 32'd1);
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    cyc;
    chk("t3_occ_done", 32'(md_occupied), 32'd0);
    chk("t3_err", 32'(err), 32'd0);

    // reset while rem = 3
    drive(1'b1, 4'd0, 32'd1, 32'd1);
    cyc;
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    cyc;
    cyc;
    cyc;
    chk("t4_occ_before", 32'(md_occupied), 32'd1);
    reset = 1'b1;
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    cyc;
    chk("t4_occ_after", 32'(md_occupied), 32'd0);
    chk("t4_op_after", 32'(md_op), 32'd8);
    chk("t4_stall_after", 32'(stall_d), 32'd0);
    reset = 1'b0;
    drive(1'b1, 4'd0, 32'd9, 32'd9);
    chk("t4_nostall", 32'(stall_d), 32'd0);
    cyc;
    chk("t4_start", 32'(md_start), 32'd1);
    chk("t4_op", 32'(md_op), 32'd0);
    chk("t4_srca", md_srca, 32'd9);
    drive(1'b0, 4'd8, 32'd0, 32'd0);
    for (int k = 0; k < 6; k++) cyc;
    chk("t4_occ_drain", 32'(md_occupied), 32'd0);
    chk("t4_err", 32'(err), 32'd0);

    // busy forced while shadow idle: sticky error until reset
    force_busy = 1'b1;
    cyc;
    chk("t5_err_set", 32'(err), 32'd1);
    force_busy = 1'b0;
    cyc;
    cyc;
    chk("t5_err_hold", 32'(err), 32'd1);
    reset = 1'b1;
    cyc;
    chk("t5_err_clear", 32'(err), 32'd0);
    reset = 1'b0;
    cyc;
    chk("t5_err_stay", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
